// File: rtl/dmem_ctrl_pkg.sv
// Shared types and constants for the data-memory access controller.
// Access-width codes, FSM states and error-cause codes.
package dmem_ctrl_pkg;

    localparam logic [3:0] BYTE     = 4'd0;
    localparam logic [3:0] HALFWORD = 4'd1;
    localparam logic [3:0] WORD     = 4'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } dmem_state_t;

    localparam logic ERR_MISALIGN = 1'b0;
    localparam logic ERR_TIMEOUT  = 1'b1;

endpackage

// File: rtl/dmem_ctrl_align.sv
// Byte-lane steering for stores, extraction/extension for loads,
// and alignment checking. Purely combinational.
module lsu_align
    import dmem_ctrl_pkg::*;
(
    input  logic [3:0]  mode,
    input  logic        uns,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_st,
    output logic [31:0] rdata_ext,
    output logic        misaligned
);

    logic        is_b;
    logic        is_h;
    logic [31:0] shifted;

    assign is_b = (mode == BYTE);
    assign is_h = (mode == HALFWORD);

    // Unknown width codes fall into the word branch.
    always_comb begin
        be         = 4'b1111;
        wdata_st   = wdata;
        rdata_ext  = rdata;
        misaligned = 1'b0;
        shifted    = rdata >> {addr, 3'b000};
        unique case (1'b1)
            is_b: begin
                be        = 4'b0001 << addr;
                wdata_st  = {4{wdata[7:0]}};
                rdata_ext = {{24{shifted[7] & ~uns}}, shifted[7:0]};
            end
            is_h: begin
                be         = addr[1] ? 4'b1100 : 4'b0011;
                wdata_st   = {2{wdata[15:0]}};
                shifted    = rdata >> {addr[1], 4'b0000};
                rdata_ext  = {{16{shifted[15] & ~uns}}, shifted[15:0]};
                misaligned = addr[0];
            end
            default: begin
                misaligned = (addr != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Multi-cycle load/store sequencer: one bus transaction per access,
// stalling the core until completion, misalignment or bus timeout.
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ls_valid,
    input  logic        ls_we,
    input  logic [3:0]  ls_mode,
    input  logic        ls_unsigned,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        stall,
    output logic        ls_done,
    output logic [31:0] ls_rdata,
    output logic        ls_err,
    output logic        err_cause,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    dmem_state_t state;
    dmem_state_t state_n;

    logic [15:0] cnt;
    logic        we_q;
    logic [31:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        cause_q;

    logic [3:0]  be_c;
    logic [31:0] wdata_c;
    logic [31:0] rdata_c;
    logic        mis_c;
    logic        accept;
    logic        timeout;

    // ls_* stay stable through REQ, so one instance serves both
    // request setup in IDLE and load extension on the ack edge.
    lsu_align u_align (
        .mode       (ls_mode),
        .uns        (ls_unsigned),
        .addr       (ls_addr[1:0]),
        .wdata      (ls_wdata),
        .rdata      (mem_rdata),
        .be         (be_c),
        .wdata_st   (wdata_c),
        .rdata_ext  (rdata_c),
        .misaligned (mis_c)
    );

    assign accept  = (state == S_IDLE) && ls_valid;
    assign timeout = (cnt == TO_LAST);

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE: begin
                if (ls_valid) state_n = mis_c ? S_ERR : S_REQ;
            end
            S_REQ: begin
                if (mem_ack)      state_n = S_DONE;
                else if (timeout) state_n = S_ERR;
            end
            S_DONE:  state_n = S_IDLE;
            S_ERR:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cause_q <= ERR_MISALIGN;
        end else if (accept) begin
            rdata_q <= '0;
            if (mis_c) begin
                cause_q <= ERR_MISALIGN;
            end else begin
                cnt     <= '0;
                we_q    <= ls_we;
                addr_q  <= {ls_addr[31:2], 2'b00};
                be_q    <= be_c;
                wdata_q <= wdata_c;
            end
        end else if (state == S_REQ) begin
            if (mem_ack) begin
                rdata_q <= we_q ? 32'h0 : rdata_c;
            end else if (timeout) begin
                cause_q <= ERR_TIMEOUT;
                rdata_q <= '0;
            end else begin
                cnt <= cnt + 16'd1;
            end
        end
    end

    assign stall     = accept || (state == S_REQ);
    assign ls_done   = (state == S_DONE);
    assign ls_rdata  = ls_done ? rdata_q : 32'h0;
    assign ls_err    = (state == S_ERR);
    assign err_cause = ls_err & cause_q;
    assign mem_req   = (state == S_REQ);
    assign mem_we    = mem_req & we_q;
    assign mem_addr  = mem_req ? addr_q : 32'h0;
    assign mem_be    = mem_req ? be_q : 4'h0;
    assign mem_wdata = mem_req ? wdata_q : 32'h0;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed and randomized checks of dmem_ctrl against a
// behavioural access model.
module tb_dmem_ctrl;
    import dmem_ctrl_pkg::*;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ls_valid = 1'b0;
    logic        ls_we = 1'b0;
    logic [3:0]  ls_mode = WORD;
    logic        ls_unsigned = 1'b0;
    logic [31:0] ls_addr = '0;
    logic [31:0] ls_wdata = '0;
    logic        stall, ls_done, ls_err, err_cause;
    logic [31:0] ls_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    int vectors = 0;
    int errs = 0;

    dmem_ctrl #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst_n(rst_n),
        .ls_valid(ls_valid), .ls_we(ls_we), .ls_mode(ls_mode),
        .ls_unsigned(ls_unsigned), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .stall(stall), .ls_done(ls_done),
        .ls_rdata(ls_rdata), .ls_err(ls_err), .err_cause(err_cause),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int width_of(input logic [3:0] m);
        if (m == BYTE) return 1;
        if (m == HALFWORD) return 2;
        return 4;
    endfunction

    function automatic bit is_mis(input logic [3:0] m, input logic [31:0] a);
        return (a % width_of(m)) != 0;
    endfunction

    function automatic logic [31:0] m_be(input logic [3:0] m, input logic [31:0] a);
        int w = width_of(m);
        int off = a % 4;
        return 32'(((1 << w) - 1) << (off - off % w));
    endfunction

    function automatic logic [31:0] m_wd(input logic [3:0] m, input logic [31:0] d);
        int w = width_of(m);
        if (w == 1) return (d & 32'hFF) * 32'h01010101;
        if (w == 2) return (d & 32'hFFFF) * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] m_rd(input logic [3:0] m, input logic u,
                                         input logic [31:0] a, input logic [31:0] d);
        int w = width_of(m);
        logic [31:0] v;
        longint span;
        if (w == 4) return d;
        span = longint'(1) << (8 * w);
        v = (d >> (8 * (a % 4))) % 32'(span);
        if (!u && v >= 32'(span / 2)) v = v - 32'(span);
        return v;
    endfunction

    task automatic run(input logic we, input logic [3:0] mode, input logic u,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] rd, input int waits);
        int nreq;
        bit tmo;
        @(negedge clk);
        ls_valid = 1'b1; ls_we = we; ls_mode = mode;
        ls_unsigned = u; ls_addr = addr; ls_wdata = wd;
        mem_ack = 1'b0;
        #1;
        chk("idle_stall", 32'(stall), 1);
        chk("idle_req", 32'(mem_req), 0);
        if (is_mis(mode, addr)) begin
            @(negedge clk);
            chk("mis_err", 32'(ls_err), 1);
            chk("mis_cause", 32'(err_cause), 0);
            chk("mis_rdata", ls_rdata, 0);
            chk("mis_done", 32'(ls_done), 0);
            chk("mis_req", 32'(mem_req), 0);
            chk("mis_stall", 32'(stall), 0);
        end else begin
            tmo = (waits >= T);
            nreq = tmo ? T : waits + 1;
            for (int k = 1; k <= nreq; k++) begin
                @(negedge clk);
                chk("req", 32'(mem_req), 1);
                chk("req_stall", 32'(stall), 1);
                chk("req_we", 32'(mem_we), 32'(we));
                chk("req_addr", mem_addr, addr & 32'hFFFF_FFFC);
                chk("req_be", 32'(mem_be), m_be(mode, addr));
                if (we) chk("req_wdata", mem_wdata, m_wd(mode, wd));
                chk("req_done", 32'(ls_done | ls_err), 0);
                if (k == nreq && !tmo) begin
                    mem_ack = 1'b1;
                    mem_rdata = rd;
                end else begin
                    mem_rdata = $urandom;
                end
            end
            @(negedge clk);
            mem_ack = 1'b0;
            if (tmo) begin
                chk("tmo_err", 32'(ls_err), 1);
                chk("tmo_cause", 32'(err_cause), 1);
                chk("tmo_done", 32'(ls_done), 0);
                chk("tmo_rdata", ls_rdata, 0);
            end else begin
                chk("done", 32'(ls_done), 1);
                chk("done_err", 32'(ls_err), 0);
                chk("done_rdata", ls_rdata, we ? 32'h0 : m_rd(mode, u, addr, rd));
            end
            chk("end_stall", 32'(stall), 0);
            chk("end_req", 32'(mem_req), 0);
        end
        ls_valid = 1'b0;
    endtask

    initial begin
        #2;
        chk("rst_req", 32'(mem_req), 0);
        chk("rst_done", 32'(ls_done), 0);
        chk("rst_err", 32'(ls_err), 0);
        chk("rst_rdata", ls_rdata, 0);
        chk("rst_stall", 32'(stall), 0);
        @(negedge clk);
        rst_n = 1'b1;

        run(1'b0, WORD, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0);
        run(1'b0, BYTE, 1'b0, 32'h103, 32'h0, 32'h80FFFFFF, 0);
        run(1'b0, BYTE, 1'b1, 32'h103, 32'h0, 32'h80FFFFFF, 0);
        run(1'b1, HALFWORD, 1'b0, 32'h202, 32'h1234ABCD, 32'h0, 4 - 1);
        run(1'b0, WORD, 1'b0, 32'h101, 32'h0, 32'h0, 0);
        run(1'b0, WORD, 1'b0, 32'h300, 32'h0, 32'h0, T);
        run(1'b0, HALFWORD, 1'b0, 32'h302, 32'h0, 32'h8001_7FFF, T - 1);
        run(1'b1, 4'hF, 1'b0, 32'h40C, 32'hCAFEF00D, 32'h0, 1);

        // Reset during the second REQ cycle, with a stray ack afterwards.
        @(negedge clk);
        ls_valid = 1'b1; ls_we = 1'b0; ls_mode = WORD; ls_addr = 32'h500;
        @(negedge clk);
        chk("rr_req1", 32'(mem_req), 1);
        @(negedge clk);
        chk("rr_req2", 32'(mem_req), 1);
        rst_n = 1'b0;
        #1;
        chk("rr_req_drop", 32'(mem_req), 0);
        chk("rr_stall", 32'(stall), 1);
        ls_valid = 1'b0;
        mem_ack = 1'b1;
        #1;
        chk("rr_stall_idle", 32'(stall), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rr_after_req", 32'(mem_req), 0);
        chk("rr_after_done", 32'(ls_done), 0);
        mem_ack = 1'b0;
        run(1'b0, WORD, 1'b0, 32'h504, 32'h0, 32'h13579BDF, 0);

        for (int i = 0; i < 60; i++) begin
            logic [3:0] md;
            case ($urandom_range(0, 3))
                0: md = BYTE;
                1: md = HALFWORD;
                2: md = WORD;
                default: md = 4'(8 + $urandom_range(0, 7));
            endcase
            run(1'($urandom), md, 1'($urandom), $urandom, $urandom,
                $urandom, $urandom_range(0, T + 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
